// File: rtl/sata_axil_regbank_pkg.sv
// Shared constants and helpers for the SATA AXI4-Lite register bank:
// response codes, per-register access modes and address decode helpers.
package sata_axil_regbank_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        MODE_RW  = 2'b00,
        MODE_RO  = 2'b01,
        MODE_W1C = 2'b10
    } reg_mode_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((32'sd1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int addr_lsb(input int dw);
        return (dw == 64) ? 3 : 2;
    endfunction

    // Read-only wins when a register is flagged both read-only and sticky.
    function automatic reg_mode_e reg_mode(input logic ro, input logic w1c);
        if (ro) begin
            return MODE_RO;
        end else if (w1c) begin
            return MODE_W1C;
        end else begin
            return MODE_RW;
        end
    endfunction

endpackage

// File: rtl/sata_axil_regbank_hold.sv
// One-entry valid/data holding register for an AXI channel; accepts while
// empty and empties when the consumer clears it.
module sata_axil_regbank_hold #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid,
    input  logic [W-1:0] data,
    input  logic         clr,
    output logic         ready,
    output logic         full,
    output logic [W-1:0] q
);

    logic         full_r;
    logic [W-1:0] data_r;

    // Capture one beat while empty; clear releases the slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_r <= 1'b0;
            data_r <= '0;
        end else if (clr) begin
            full_r <= 1'b0;
            data_r <= data_r;
        end else if (valid && !full_r) begin
            full_r <= 1'b1;
            data_r <= data;
        end else begin
            full_r <= full_r;
            data_r <= data_r;
        end
    end

    assign ready = ~full_r;
    assign full  = full_r;
    assign q     = data_r;

endmodule

// File: rtl/sata_axil_regbank.sv
// Parametrised AXI4-Lite register bank with per-register RW / RO / W1C modes,
// decoupled AW and W acceptance and one-cycle write strobes.
module sata_axil_regbank
    import sata_axil_regbank_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 8,
    parameter int NUM_REGS       = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK  = '0,
    parameter logic [NUM_REGS-1:0] W1C_MASK = '0,
    parameter logic [NUM_REGS*AXI_DATA_WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                               S_AXI_ACLK,
    input  logic                               S_AXI_ARESETN,
    input  logic [AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                         S_AXI_AWPROT,
    input  logic                               S_AXI_AWVALID,
    output logic                               S_AXI_AWREADY,
    input  logic [AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                               S_AXI_WVALID,
    output logic                               S_AXI_WREADY,
    output logic [1:0]                         S_AXI_BRESP,
    output logic                               S_AXI_BVALID,
    input  logic                               S_AXI_BREADY,
    input  logic [AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                         S_AXI_ARPROT,
    input  logic                               S_AXI_ARVALID,
    output logic                               S_AXI_ARREADY,
    output logic [AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                         S_AXI_RRESP,
    output logic                               S_AXI_RVALID,
    input  logic                               S_AXI_RREADY,
    output logic [NUM_REGS*AXI_DATA_WIDTH-1:0] ctrl_o,
    input  logic [NUM_REGS*AXI_DATA_WIDTH-1:0] status_i,
    input  logic [NUM_REGS*AXI_DATA_WIDTH-1:0] evt_i,
    output logic [NUM_REGS-1:0]                wr_pulse_o
);

    localparam int DW       = AXI_DATA_WIDTH;
    localparam int STRB_W   = DW / 8;
    localparam int ADDR_LSB = addr_lsb(DW);
    localparam int IDX_W    = (clog2(NUM_REGS) < 1) ? 1 : clog2(NUM_REGS);
    localparam int LUT_N    = 2 ** IDX_W;
    localparam logic [AXI_ADDR_WIDTH:0] ADDR_LIMIT = (AXI_ADDR_WIDTH + 1)'(NUM_REGS * STRB_W);

    logic [1:0]              rst_sync_r;
    logic                    rst_n_s;
    logic                    aw_full_s, w_full_s, commit_s;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr_s;
    logic [DW-1:0]           w_data_s, wr_mask_s;
    logic [STRB_W-1:0]       w_strb_s;
    logic                    wr_in_range_s, rd_in_range_s, ar_hs_s;
    logic [IDX_W-1:0]        wr_idx_s, rd_idx_s;
    logic [NUM_REGS-1:0]     wr_sel_s;
    logic [LUT_N-1:0]        lut_ro_s;
    logic [DW-1:0]           rd_words_s [LUT_N];
    logic [1:0]              wr_resp_s, rd_resp_s;
    logic [DW-1:0]           rd_data_s;
    logic                    bvalid_r, rvalid_r;
    logic [1:0]              bresp_r, rresp_r;
    logic [DW-1:0]           rdata_r;
    logic [NUM_REGS-1:0]     wr_pulse_r;
    logic                    unused_s;

    // Reset asserts asynchronously and is released in step with the clock.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end
    assign rst_n_s = rst_sync_r[1];

    sata_axil_regbank_hold #(.W(AXI_ADDR_WIDTH)) u_aw_hold (
        .clk(S_AXI_ACLK), .rst_n(rst_n_s), .valid(S_AXI_AWVALID), .data(S_AXI_AWADDR),
        .clr(commit_s), .ready(S_AXI_AWREADY), .full(aw_full_s), .q(aw_addr_s)
    );

    sata_axil_regbank_hold #(.W(DW + STRB_W)) u_w_hold (
        .clk(S_AXI_ACLK), .rst_n(rst_n_s), .valid(S_AXI_WVALID), .data({S_AXI_WSTRB, S_AXI_WDATA}),
        .clr(commit_s), .ready(S_AXI_WREADY), .full(w_full_s), .q({w_strb_s, w_data_s})
    );

    assign commit_s      = aw_full_s & w_full_s & (~bvalid_r | S_AXI_BREADY);
    assign wr_in_range_s = {1'b0, aw_addr_s} < ADDR_LIMIT;
    assign wr_idx_s      = aw_addr_s[ADDR_LSB +: IDX_W];
    assign rd_in_range_s = {1'b0, S_AXI_ARADDR} < ADDR_LIMIT;
    assign rd_idx_s      = S_AXI_ARADDR[ADDR_LSB +: IDX_W];
    assign ar_hs_s       = S_AXI_ARVALID & ~rvalid_r;

    for (genvar b = 0; b < STRB_W; b++) begin : g_lane
        assign wr_mask_s[b*8 +: 8] = {8{w_strb_s[b]}};
    end

    // Lookup tables padded to a power of two so any decoded index is legal.
    for (genvar i = 0; i < LUT_N; i++) begin : g_lut
        if (i < NUM_REGS) begin : g_used
            assign lut_ro_s[i]   = RO_MASK[i];
            assign rd_words_s[i] = RO_MASK[i] ? status_i[i*DW +: DW] : ctrl_o[i*DW +: DW];
        end else begin : g_pad
            assign lut_ro_s[i]   = 1'b0;
            assign rd_words_s[i] = '0;
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        localparam reg_mode_e MODE = reg_mode(RO_MASK[i], W1C_MASK[i]);
        assign wr_sel_s[i] = commit_s & wr_in_range_s & (wr_idx_s == IDX_W'(i)) & ~RO_MASK[i];
        if (MODE == MODE_RO) begin : g_ro
            assign ctrl_o[i*DW +: DW] = '0;
        end else if (MODE == MODE_W1C) begin : g_w1c
            logic [DW-1:0] val_r;
            // Clear-by-write is applied first so a same-edge event keeps the bit set.
            always_ff @(posedge S_AXI_ACLK or negedge rst_n_s) begin
                if (!rst_n_s) begin
                    val_r <= '0;
                end else if (wr_sel_s[i]) begin
                    val_r <= (val_r & ~(w_data_s & wr_mask_s)) | evt_i[i*DW +: DW];
                end else begin
                    val_r <= val_r | evt_i[i*DW +: DW];
                end
            end
            assign ctrl_o[i*DW +: DW] = val_r;
        end else begin : g_rw
            logic [DW-1:0] val_r;
            // Byte-lane update of a control register.
            always_ff @(posedge S_AXI_ACLK or negedge rst_n_s) begin
                if (!rst_n_s) begin
                    val_r <= RESET_VAL[i*DW +: DW];
                end else if (wr_sel_s[i]) begin
                    val_r <= (val_r & ~wr_mask_s) | (w_data_s & wr_mask_s);
                end else begin
                    val_r <= val_r;
                end
            end
            assign ctrl_o[i*DW +: DW] = val_r;
        end
    end

    // Response code for the pending write and for the incoming read.
    always_comb begin
        wr_resp_s = RESP_OKAY;
        rd_resp_s = RESP_OKAY;
        rd_data_s = '0;
        if (!wr_in_range_s) begin
            wr_resp_s = RESP_DECERR;
        end else if (lut_ro_s[wr_idx_s]) begin
            wr_resp_s = RESP_SLVERR;
        end else begin
            wr_resp_s = RESP_OKAY;
        end
        if (rd_in_range_s) begin
            rd_data_s = rd_words_s[rd_idx_s];
            rd_resp_s = RESP_OKAY;
        end else begin
            rd_data_s = '0;
            rd_resp_s = RESP_DECERR;
        end
    end

    // Write response channel and per-register write strobes.
    always_ff @(posedge S_AXI_ACLK or negedge rst_n_s) begin
        if (!rst_n_s) begin
            bvalid_r   <= 1'b0;
            bresp_r    <= RESP_OKAY;
            wr_pulse_r <= '0;
        end else begin
            wr_pulse_r <= wr_sel_s;
            if (commit_s) begin
                bvalid_r <= 1'b1;
                bresp_r  <= wr_resp_s;
            end else if (S_AXI_BREADY) begin
                bvalid_r <= 1'b0;
                bresp_r  <= bresp_r;
            end else begin
                bvalid_r <= bvalid_r;
                bresp_r  <= bresp_r;
            end
        end
    end

    // Read data channel; data is captured on the address handshake.
    always_ff @(posedge S_AXI_ACLK or negedge rst_n_s) begin
        if (!rst_n_s) begin
            rvalid_r <= 1'b0;
            rresp_r  <= RESP_OKAY;
            rdata_r  <= '0;
        end else if (ar_hs_s) begin
            rvalid_r <= 1'b1;
            rresp_r  <= rd_resp_s;
            rdata_r  <= rd_data_s;
        end else if (S_AXI_RREADY) begin
            rvalid_r <= 1'b0;
            rresp_r  <= rresp_r;
            rdata_r  <= rdata_r;
        end else begin
            rvalid_r <= rvalid_r;
            rresp_r  <= rresp_r;
            rdata_r  <= rdata_r;
        end
    end

    assign S_AXI_BVALID  = bvalid_r;
    assign S_AXI_BRESP   = bresp_r;
    assign S_AXI_ARREADY = ~rvalid_r;
    assign S_AXI_RVALID  = rvalid_r;
    assign S_AXI_RRESP   = rresp_r;
    assign S_AXI_RDATA   = rdata_r;
    assign wr_pulse_o    = wr_pulse_r;
    assign unused_s      = ^{S_AXI_AWPROT, S_AXI_ARPROT, status_i, evt_i};

endmodule

// File: tb/tb_sata_axil_regbank.sv
// Directed plus randomized bench for sata_axil_regbank against a per-register
// behavioural model of the RW / RO / W1C access rules.
module tb_sata_axil_regbank;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int NR = 16;
    localparam logic [NR-1:0] RO_M  = 16'h1208;
    localparam logic [NR-1:0] W1C_M = 16'h2224;
    localparam logic [NR*DW-1:0] RST_V = mk_rst();

    function automatic logic [NR*DW-1:0] mk_rst();
        logic [NR*DW-1:0] v;
        for (int i = 0; i < NR; i++) v[i*DW +: DW] = 32'h5A5A_C300 | 32'(i);
        return v;
    endfunction

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [AW-1:0]   awaddr = '0, araddr = '0;
    logic [2:0]      awprot = 3'd0, arprot = 3'd0;
    logic            awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
    logic            bready = 1'b1, rready = 1'b1;
    logic [DW-1:0]   wdata = '0;
    logic [3:0]      wstrb = 4'h0;
    logic            awready, wready, bvalid, arready, rvalid;
    logic [1:0]      bresp, rresp;
    logic [DW-1:0]   rdata;
    logic [NR*DW-1:0] ctrl, status = '0, evt = '0;
    logic [NR-1:0]   pulse;

    logic [DW-1:0]   m_reg [NR];
    int checks = 0;
    int errors = 0;

    sata_axil_regbank #(
        .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .NUM_REGS(NR),
        .RO_MASK(RO_M), .W1C_MASK(W1C_M), .RESET_VAL(RST_V)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rstn),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .ctrl_o(ctrl), .status_i(status), .evt_i(evt), .wr_pulse_o(pulse)
    );

    always #5 clk = ~clk;

    function automatic bit is_ro(input int i);
        return RO_M[i];
    endfunction

    function automatic bit is_w1c(input int i);
        return W1C_M[i] && !RO_M[i];
    endfunction

    function automatic logic [NR*DW-1:0] exp_ctrl();
        logic [NR*DW-1:0] v;
        for (int i = 0; i < NR; i++) v[i*DW +: DW] = is_ro(i) ? 32'h0 : m_reg[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_reg[i] = (is_ro(i) || is_w1c(i)) ? 32'h0 : RST_V[i*DW +: DW];
    endtask

    task automatic w1c_or(input logic [NR*DW-1:0] ev);
        for (int i = 0; i < NR; i++) if (is_w1c(i)) m_reg[i] = m_reg[i] | ev[i*DW +: DW];
    endtask

    task automatic chk(input string tag, input logic [NR*DW-1:0] obs, input logic [NR*DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NR*DW-1:0] sparse_evt();
        logic [NR*DW-1:0] v;
        for (int i = 0; i < NR; i++) v[i*DW +: DW] = $urandom & $urandom & $urandom;
        return v;
    endfunction

    // gap > 0: W leads AW by gap cycles; gap < 0: AW leads W; ev is driven on the commit edge.
    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [3:0] strb,
                            input int gap, input logic [NR*DW-1:0] ev);
        logic [1:0]    er;
        logic [NR-1:0] ep;
        logic [DW-1:0] bm;
        int            idx;
        int            lat;
        if (gap >= 0) begin
            wdata = data; wstrb = strb; wvalid = 1'b1;
            if (gap == 0) begin awaddr = addr; awvalid = 1'b1; end
            tick();
            wvalid = 1'b0; awvalid = 1'b0;
            if (gap > 0) begin
                repeat (gap - 1) tick();
                awaddr = addr; awvalid = 1'b1;
                tick();
                awvalid = 1'b0;
            end
        end else begin
            awaddr = addr; awvalid = 1'b1;
            tick();
            awvalid = 1'b0;
            repeat (-gap - 1) tick();
            wdata = data; wstrb = strb; wvalid = 1'b1;
            tick();
            wvalid = 1'b0;
        end
        chk("b_early", 512'(bvalid), 512'(1'b0));
        evt = ev;
        tick();
        evt = '0;
        lat = 1;
        while (!bvalid && lat < 8) begin tick(); lat++; end
        chk("b_latency", 512'(lat), 512'(1));
        ep = '0;
        if (addr >= 8'd64) begin
            er = 2'b11;
        end else begin
            idx = int'(addr) / 4;
            for (int b = 0; b < 4; b++) bm[b*8 +: 8] = strb[b] ? 8'hFF : 8'h00;
            if (is_ro(idx)) begin
                er = 2'b10;
            end else begin
                er = 2'b00;
                ep[idx] = 1'b1;
                if (is_w1c(idx)) m_reg[idx] = m_reg[idx] & ~(data & bm);
                else m_reg[idx] = (m_reg[idx] & ~bm) | (data & bm);
            end
        end
        w1c_or(ev);
        chk("bresp", 512'(bresp), 512'(er));
        chk("wr_pulse", 512'(pulse), 512'(ep));
        chk("ctrl_after_wr", ctrl, exp_ctrl());
        tick();
        chk("b_done", 512'(bvalid), 512'(1'b0));
        chk("pulse_clear", 512'(pulse), 512'(0));
    endtask

    task automatic do_read(input logic [AW-1:0] addr);
        logic [DW-1:0] ed;
        logic [1:0]    er;
        int            idx;
        if (addr >= 8'd64) begin
            ed = 32'h0; er = 2'b11;
        end else begin
            idx = int'(addr) / 4;
            ed = is_ro(idx) ? status[idx*DW +: DW] : m_reg[idx];
            er = 2'b00;
        end
        chk("ar_ready", 512'(arready), 512'(1'b1));
        araddr = addr; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        chk("r_valid", 512'(rvalid), 512'(1'b1));
        chk("r_data", 512'(rdata), 512'(ed));
        chk("r_resp", 512'(rresp), 512'(er));
        tick();
        chk("r_done", 512'(rvalid), 512'(1'b0));
    endtask

    task automatic evt_pulse(input logic [NR*DW-1:0] ev);
        evt = ev;
        tick();
        evt = '0;
        w1c_or(ev);
        chk("ctrl_after_evt", ctrl, exp_ctrl());
    endtask

    initial begin
        logic [NR*DW-1:0] ev;
        for (int i = 0; i < NR; i++) status[i*DW +: DW] = $urandom;
        model_reset();

        // Reset state
        repeat (3) tick();
        chk("rst_awready", 512'(awready), 512'(1'b1));
        chk("rst_wready", 512'(wready), 512'(1'b1));
        chk("rst_arready", 512'(arready), 512'(1'b1));
        chk("rst_bvalid", 512'({bvalid, bresp}), 512'(0));
        chk("rst_rvalid", 512'({rvalid, rresp, rdata}), 512'(0));
        chk("rst_pulse", 512'(pulse), 512'(0));
        chk("rst_ctrl", ctrl, exp_ctrl());
        rstn = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < NR; i++) do_read(8'(i * 4));

        // W three cycles ahead of AW, partial strobe
        do_write(8'h04, 32'hA5A5_1234, 4'b0011, 3, '0);
        chk("reg1_value", 512'(ctrl[1*DW +: DW]), 512'(32'h5A5A_1234));

        // Back-pressured response with a second write queued behind it
        bready = 1'b0;
        awaddr = 8'h00; wdata = 32'h1357_9BDF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        m_reg[0] = 32'h1357_9BDF;
        chk("bp_bvalid1", 512'(bvalid), 512'(1'b1));
        chk("bp_pulse1", 512'(pulse), 512'(16'h0001));
        awaddr = 8'h10; wdata = 32'hDEAD_BEEF; awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("bp_aw_held", 512'({awready, wready}), 512'(2'b00));
        for (int n = 0; n < 4; n++) begin
            chk("bp_hold_bvalid", 512'(bvalid), 512'(1'b1));
            chk("bp_no_commit", ctrl, exp_ctrl());
            tick();
        end
        bready = 1'b1;
        tick();
        m_reg[4] = 32'hDEAD_BEEF;
        chk("bp_bvalid2", 512'(bvalid), 512'(1'b1));
        chk("bp_pulse2", 512'(pulse), 512'(16'h0010));
        chk("bp_ctrl2", ctrl, exp_ctrl());
        tick();
        chk("bp_b_done", 512'(bvalid), 512'(1'b0));

        // Sticky register: event set, clear racing a new event, plain clear
        ev = '0; ev[2*DW] = 1'b1;
        evt_pulse(ev);
        do_read(8'h08);
        do_write(8'h08, 32'h1, 4'hF, 0, ev);
        chk("w1c_set_wins", 512'(ctrl[2*DW +: DW]), 512'(32'h1));
        do_write(8'h08, 32'h1, 4'hF, -2, '0);
        chk("w1c_cleared", 512'(ctrl[2*DW +: DW]), 512'(32'h0));

        // Read-only, overlapped-mask and out-of-range accesses
        do_write(8'h0C, 32'hFFFF_FFFF, 4'hF, 0, '0);
        do_read(8'h0C);
        do_write(8'h24, 32'hFFFF_FFFF, 4'hF, 1, '0);
        do_read(8'h24);
        do_write(8'h40, 32'hFFFF_FFFF, 4'hF, 0, '0);
        do_read(8'h40);
        do_read(8'hFC);

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 3))
                0, 1: do_write(8'($urandom_range(0, 8'h4F)), $urandom, 4'($urandom_range(0, 15)),
                               int'($urandom_range(0, 6)) - 3, ($urandom_range(0, 1) == 1) ? sparse_evt() : '0);
                2: do_read(8'($urandom_range(0, 8'h4F)));
                default: begin
                    for (int i = 0; i < NR; i++) status[i*DW +: DW] = $urandom;
                    evt_pulse(sparse_evt());
                end
            endcase
        end

        // Reset in the middle of a stalled read
        rready = 1'b0;
        araddr = 8'h00; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        chk("mid_rvalid", 512'(rvalid), 512'(1'b1));
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_rvalid", 512'(rvalid), 512'(1'b0));
        rready = 1'b1;
        repeat (2) tick();
        rstn = 1'b1;
        repeat (3) tick();
        model_reset();
        chk("post_rst_ready", 512'({awready, wready, arready}), 512'(3'b111));
        chk("post_rst_bvalid", 512'({bvalid, rvalid}), 512'(2'b00));
        chk("post_rst_ctrl", ctrl, exp_ctrl());
        for (int i = 0; i < NR; i++) do_read(8'(i * 4));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
